// File: rtl/vga_blob_centroid.sv
// rtl/vga_blob_centroid.sv - per-frame bright-blob count, centroid and bounding box
// Thresholds the gated raster stream, then divides coordinate sums by count one bit per cycle.
module vga_blob_centroid #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int PIX_W     = 8,
  parameter int THRESH    = 200,
  parameter int MIN_COUNT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_grayscale_start,
  input  logic             i_VGA_VSYNC,
  input  logic             i_pix_valid,
  input  logic [PIX_W-1:0] i_pix_gray,
  output logic             o_valid,
  output logic             o_found,
  output logic [9:0]       o_cx,
  output logic [9:0]       o_cy,
  output logic [9:0]       o_min_x,
  output logic [9:0]       o_max_x,
  output logic [9:0]       o_min_y,
  output logic [9:0]       o_max_y,
  output logic [18:0]      o_count,
  output logic             o_busy
);
  localparam int CNT_W = 19;
  localparam int SUM_W = 28;
  localparam int XW    = 10;
  localparam int YW    = 10;
  localparam logic [XW-1:0]    X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]    Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [PIX_W-1:0] THR    = PIX_W'(THRESH);
  localparam logic [CNT_W-1:0] MINC   = CNT_W'(MIN_COUNT);
  localparam logic [4:0]       DIV_LAST = 5'(SUM_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_ACCUM, S_DIVIDE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SUM_W-1:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [CNT_W-1:0]  rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [XW-1:0]     bmin_x_q, bmin_x_d, bmax_x_q, bmax_x_d;
  logic [YW-1:0]     bmin_y_q, bmin_y_d, bmax_y_q, bmax_y_d;
  logic [4:0]        div_cnt_q, div_cnt_d;
  logic              valid_q, valid_d, found_q, found_d;
  logic [9:0]        cx_q, cx_d, cy_q, cy_d;
  logic [9:0]        min_x_q, min_x_d, max_x_q, max_x_d, min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CNT_W-1:0]  ocount_q, ocount_d;

  // Sums double as the quotient shift registers while dividing.
  logic [CNT_W:0] rem_x_sh, rem_y_sh, diff_x, diff_y;
  logic           ge_x, ge_y;
  assign rem_x_sh = {rem_x_q, sum_x_q[SUM_W-1]};
  assign rem_y_sh = {rem_y_q, sum_y_q[SUM_W-1]};
  assign diff_x   = rem_x_sh - {1'b0, count_q};
  assign diff_y   = rem_y_sh - {1'b0, count_q};
  assign ge_x     = rem_x_sh >= {1'b0, count_q};
  assign ge_y     = rem_y_sh >= {1'b0, count_q};

  always_comb begin
    state_d   = state_q;   x_d = x_q;   y_d = y_q;   count_d = count_q;
    sum_x_d   = sum_x_q;   sum_y_d = sum_y_q;   rem_x_d = rem_x_q;   rem_y_d = rem_y_q;
    bmin_x_d  = bmin_x_q;  bmax_x_d = bmax_x_q; bmin_y_d = bmin_y_q; bmax_y_d = bmax_y_q;
    div_cnt_d = div_cnt_q; valid_d = 1'b0;      found_d = found_q;
    cx_d      = cx_q;      cy_d = cy_q;         ocount_d = ocount_q;
    min_x_d   = min_x_q;   max_x_d = max_x_q;   min_y_d = min_y_q;   max_y_d = max_y_q;
    case (state_q)
      S_IDLE: if (i_grayscale_start && !i_VGA_VSYNC) state_d = S_ARMED;
      S_ARMED: begin
        x_d = '0; y_d = '0; count_d = '0; sum_x_d = '0; sum_y_d = '0;
        rem_x_d = '0; rem_y_d = '0; div_cnt_d = '0;
        bmin_x_d = '0; bmax_x_d = '0; bmin_y_d = '0; bmax_y_d = '0;
        if (!i_grayscale_start) state_d = S_IDLE;
        else if (i_VGA_VSYNC)   state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (!i_grayscale_start) state_d = S_IDLE;
        else if (!i_VGA_VSYNC)  state_d = S_ARMED;
        else if (i_pix_valid) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          if (i_pix_gray >= THR) begin
            count_d = count_q + CNT_W'(1);
            sum_x_d = sum_x_q + SUM_W'(x_q);
            sum_y_d = sum_y_q + SUM_W'(y_q);
            if (count_q == '0) begin
              bmin_x_d = x_q; bmax_x_d = x_q; bmin_y_d = y_q; bmax_y_d = y_q;
            end else begin
              if (x_q < bmin_x_q) bmin_x_d = x_q;
              if (x_q > bmax_x_q) bmax_x_d = x_q;
              if (y_q < bmin_y_q) bmin_y_d = y_q;
              if (y_q > bmax_y_q) bmax_y_d = y_q;
            end
          end
          if (x_q == X_LAST && y_q == Y_LAST)
            state_d = (count_d >= MINC) ? S_DIVIDE : S_DONE;
        end
      end
      S_DIVIDE: begin
        if (!i_grayscale_start) state_d = S_IDLE;
        else begin
          sum_x_d   = {sum_x_q[SUM_W-2:0], ge_x};
          sum_y_d   = {sum_y_q[SUM_W-2:0], ge_y};
          rem_x_d   = ge_x ? diff_x[CNT_W-1:0] : rem_x_sh[CNT_W-1:0];
          rem_y_d   = ge_y ? diff_y[CNT_W-1:0] : rem_y_sh[CNT_W-1:0];
          div_cnt_d = div_cnt_q + 5'd1;
          if (div_cnt_q == DIV_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        valid_d  = 1'b1;
        ocount_d = count_q;
        found_d  = count_q >= MINC;
        if (count_q >= MINC) begin
          cx_d = sum_x_q[9:0];    cy_d = sum_y_q[9:0];
          min_x_d = bmin_x_q;     max_x_d = bmax_x_q;
          min_y_d = bmin_y_q;     max_y_d = bmax_y_q;
        end else begin
          cx_d = '0; cy_d = '0; min_x_d = '0; max_x_d = '0; min_y_d = '0; max_y_d = '0;
        end
        state_d = i_grayscale_start ? S_ARMED : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;  x_q <= '0;  y_q <= '0;  count_q <= '0;
      sum_x_q <= '0;  sum_y_q <= '0;  rem_x_q <= '0;  rem_y_q <= '0;
      bmin_x_q <= '0; bmax_x_q <= '0; bmin_y_q <= '0; bmax_y_q <= '0;
      div_cnt_q <= '0; valid_q <= 1'b0; found_q <= 1'b0; cx_q <= '0; cy_q <= '0;
      min_x_q <= '0;  max_x_q <= '0;  min_y_q <= '0;  max_y_q <= '0;  ocount_q <= '0;
    end else begin
      state_q <= state_d;  x_q <= x_d;  y_q <= y_d;  count_q <= count_d;
      sum_x_q <= sum_x_d;  sum_y_q <= sum_y_d;  rem_x_q <= rem_x_d;  rem_y_q <= rem_y_d;
      bmin_x_q <= bmin_x_d; bmax_x_q <= bmax_x_d; bmin_y_q <= bmin_y_d; bmax_y_q <= bmax_y_d;
      div_cnt_q <= div_cnt_d; valid_q <= valid_d; found_q <= found_d; cx_q <= cx_d; cy_q <= cy_d;
      min_x_q <= min_x_d;  max_x_q <= max_x_d;  min_y_q <= min_y_d;  max_y_q <= max_y_d;
      ocount_q <= ocount_d;
    end
  end

  assign o_valid = valid_q;
  assign o_found = found_q;
  assign o_cx    = cx_q;
  assign o_cy    = cy_q;
  assign o_min_x = min_x_q;
  assign o_max_x = max_x_q;
  assign o_min_y = min_y_q;
  assign o_max_y = max_y_q;
  assign o_count = ocount_q;
  assign o_busy  = (state_q == S_ACCUM) || (state_q == S_DIVIDE);
endmodule

// File: tb/tb_vga_blob_centroid.sv
// tb/tb_vga_blob_centroid.sv - scoreboard bench for vga_blob_centroid on a 64x48 raster
module tb_vga_blob_centroid;
  localparam int H = 64;
  localparam int V = 48;

  logic        clk = 1'b0;
  logic        rst, gate, vsync, pv;
  logic [7:0]  gray;
  logic        o_valid, o_found, o_busy;
  logic [9:0]  o_cx, o_cy, o_min_x, o_max_x, o_min_y, o_max_y;
  logic [18:0] o_count;

  vga_blob_centroid #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_clk(clk), .i_rst(rst), .i_grayscale_start(gate), .i_VGA_VSYNC(vsync),
    .i_pix_valid(pv), .i_pix_gray(gray), .o_valid(o_valid), .o_found(o_found),
    .o_cx(o_cx), .o_cy(o_cy), .o_min_x(o_min_x), .o_max_x(o_max_x),
    .o_min_y(o_min_y), .o_max_y(o_max_y), .o_count(o_count), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rx0, rx1, ry0, ry1;
    bit corners;
    int hi, lo;
    bit found;
    int count, cx, cy, mnx, mxx, mny, mxy;
  } vec_t;

  typedef struct {
    bit found;
    int count, cx, cy, mnx, mxx, mny, mxy;
    int cyc;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  exp_t last_exp;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int vi, input int x, input int y);
    vec_t v;
    bit   b;
    v = vecs[vi];
    b = (x >= v.rx0 && x <= v.rx1 && y >= v.ry0 && y <= v.ry1) ||
        (v.corners && ((x == 0 && y == 0) || (x == H-1 && y == V-1)));
    return b ? 8'(v.hi) : 8'(v.lo);
  endfunction

  always @(negedge clk) begin
    if (o_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_o_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("valid_latency_cycle", cyc, e.cyc);
        chk("o_found", int'(o_found), int'(e.found));
        chk("o_count", int'(o_count), e.count);
        chk("o_cx", int'(o_cx), e.cx);
        chk("o_cy", int'(o_cy), e.cy);
        chk("o_min_x", int'(o_min_x), e.mnx);
        chk("o_max_x", int'(o_max_x), e.mxx);
        chk("o_min_y", int'(o_min_y), e.mny);
        chk("o_max_y", int'(o_max_y), e.mxy);
        last_exp = e;
      end
    end
  end

  task automatic check_hold();
    chk("hold_o_count", int'(o_count), last_exp.count);
    chk("hold_o_cx", int'(o_cx), last_exp.cx);
    chk("hold_o_cy", int'(o_cy), last_exp.cy);
    chk("hold_o_max_x", int'(o_max_x), last_exp.mxx);
  endtask

  // gate_drop_at: pixel index presented with gate low; vs_drop_line: line where vsync falls early.
  task automatic run_frame(input int vi, input int gate_drop_at, input int vs_drop_line,
                           input bit rst_in_div);
    int   n = 0;
    bit   aborted = 0;
    exp_t e;
    @(negedge clk);
    pv = 0; vsync = 0; gate = 1;
    repeat (3) @(negedge clk);
    vsync = 1;
    repeat (2) @(negedge clk);
    for (int y = 0; y < V && !aborted; y++) begin
      for (int x = 0; x < H && !aborted; x++) begin
        if (y == vs_drop_line) begin
          vsync = 0; pv = 0; aborted = 1;
        end else begin
          pv = 1; gray = pix_val(vi, x, y);
          if (n == gate_drop_at) begin
            gate = 0; aborted = 1;
          end else if (x == H-1 && y == V-1 && !rst_in_div) begin
            e.found = vecs[vi].found; e.count = vecs[vi].count;
            e.cx = vecs[vi].cx;   e.cy = vecs[vi].cy;
            e.mnx = vecs[vi].mnx; e.mxx = vecs[vi].mxx;
            e.mny = vecs[vi].mny; e.mxy = vecs[vi].mxy;
            e.cyc = cyc + 1 + (vecs[vi].found ? 29 : 1);
            sb.push_back(e);
          end
          n++;
        end
        @(negedge clk);
      end
      pv = 0; gray = 0;
      @(negedge clk);
    end
    vsync = 0;
    if (rst_in_div) begin
      repeat (5) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("rst_div_o_valid", int'(o_valid), 0);
      chk("rst_div_o_found", int'(o_found), 0);
      chk("rst_div_o_cx", int'(o_cx), 0);
      chk("rst_div_o_cy", int'(o_cy), 0);
      chk("rst_div_box", int'(o_min_x) + int'(o_max_x) + int'(o_min_y) + int'(o_max_y), 0);
      chk("rst_div_o_count", int'(o_count), 0);
      chk("rst_div_o_busy", int'(o_busy), 0);
      last_exp = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    end
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      chk("result_timeout_pending", sb.size(), 0);
      sb.delete();
    end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    // rx0 rx1 ry0 ry1 corners hi lo | found count cx cy minx maxx miny maxy
    vecs[0] = '{10, 19,  5, 14, 0, 255,   0, 1, 100, 14,  9, 10, 19,  5, 14};
    vecs[1] = '{40, 47,  3,  3, 0, 255,   0, 0,   8,  0,  0,  0,  0,  0,  0};
    vecs[2] = '{30, 36, 20, 21, 1, 255,   0, 1,  16, 32, 20,  0, 63,  0, 47};
    vecs[3] = '{ 0, 63, 47, 47, 0, 200, 199, 1,  64, 31, 47,  0, 63, 47, 47};
    vecs[4] = '{ 5,  8,  1,  4, 0, 255, 100, 1,  16,  6,  2,  5,  8,  1,  4};
    vecs[5] = '{ 5,  9,  1,  3, 0, 255,   0, 0,  15,  0,  0,  0,  0,  0,  0};
    vecs[6] = '{ 1,  0,  0,  0, 0, 255,   0, 0,   0,  0,  0,  0,  0,  0,  0};
    last_exp = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1; gate = 0; vsync = 0; pv = 0; gray = 0;
    repeat (3) @(negedge clk);
    chk("reset_o_valid", int'(o_valid), 0);
    chk("reset_o_busy", int'(o_busy), 0);
    chk("reset_o_count", int'(o_count), 0);
    chk("reset_o_cx", int'(o_cx), 0);
    rst = 0;

    for (int i = 0; i < 7; i++) run_frame(i, -1, -1, 0);

    run_frame(0, 1000, -1, 0);
    check_hold();
    run_frame(2, -1, -1, 0);

    run_frame(1, -1, 30, 0);
    check_hold();
    run_frame(3, -1, -1, 0);

    run_frame(0, H*V-1, -1, 0);
    check_hold();

    run_frame(0, -1, -1, 1);
    run_frame(4, -1, -1, 0);
    run_frame(0, -1, -1, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
